// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Used by the top-level FSM and by the per-digit dabble cell.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [3:0] BCD_BLANK     = 4'hF;
  localparam logic [3:0] BCD_NINE      = 4'h9;
  localparam logic [3:0] DABBLE_THRESH = 4'd5;

  // The counter has to hold BIN_W itself, not just BIN_W-1.
  function automatic int cnt_width(input int bin_w);
    return $clog2(bin_w + 1);
  endfunction

endpackage

// File: rtl/bcd_dabble_digit.sv
// One BCD digit of the double-dabble chain: add-3 correction, then shift
// left by one bit, taking shift_in at the bottom and passing the top bit on.
module bcd_dabble_digit
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       shift_in,
  output logic [3:0] digit_next,
  output logic       shift_out
);

  logic [3:0] adj;

  assign adj        = (digit >= DABBLE_THRESH) ? digit + 4'd3 : digit;
  assign digit_next = {adj[2:0], shift_in};
  assign shift_out  = adj[3];

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per cycle,
// with optional leading-zero blanking and overflow saturation to all nines.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for start; outputs hold the last result
//   SHIFT  | one dabble+shift step per cycle, BIN_W cycles in total
//   FINISH | publish result (blanked or saturated), raise done next edge
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 17,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  lz_blank,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int CNT_W = cnt_width(BIN_W);
  localparam int BCD_W = 4 * DIGITS;

  // Reset shows a single "0" with every higher digit blank.
  localparam logic [BCD_W-1:0] BCD_RESET = {{(DIGITS-1){BCD_BLANK}}, 4'h0};
  localparam logic [BCD_W-1:0] BCD_SAT   = {DIGITS{BCD_NINE}};

  state_t             state;
  state_t             state_nxt;
  logic [BIN_W-1:0]   bin_reg;
  logic [BCD_W-1:0]   scratch;
  logic [BCD_W-1:0]   scratch_nxt;
  logic [DIGITS:0]    chain;
  logic [CNT_W-1:0]   cnt;
  logic               lz_reg;
  logic               ovf_sticky;
  logic [BCD_W-1:0]   blanked;
  logic               seen;

  assign chain[0] = bin_reg[BIN_W-1];

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_dabble_digit u_digit (
      .digit      (scratch[4*g +: 4]),
      .shift_in   (chain[g]),
      .digit_next (scratch_nxt[4*g +: 4]),
      .shift_out  (chain[g+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == CNT_W'(1)) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Blank every digit above the most significant nonzero one; digit 0 stays.
  always_comb begin
    blanked = scratch;
    seen    = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (scratch[4*i +: 4] != 4'h0) seen = 1'b1;
      if (lz_reg && !seen) blanked[4*i +: 4] = BCD_BLANK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_reg    <= '0;
      scratch    <= '0;
      cnt        <= '0;
      lz_reg     <= 1'b0;
      ovf_sticky <= 1'b0;
      done       <= 1'b0;
      ovf        <= 1'b0;
      bcd_out    <= BCD_RESET;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_reg    <= bin_in;
            lz_reg     <= lz_blank;
            scratch    <= '0;
            ovf_sticky <= 1'b0;
            cnt        <= CNT_W'(BIN_W);
          end
        end
        SHIFT: begin
          scratch <= scratch_nxt;
          bin_reg <= {bin_reg[BIN_W-2:0], 1'b0};
          cnt     <= cnt - CNT_W'(1);
          if (chain[DIGITS]) ovf_sticky <= 1'b1;
        end
        FINISH: begin
          done    <= 1'b1;
          ovf     <= ovf_sticky;
          bcd_out <= ovf_sticky ? BCD_SAT : blanked;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Randomized and directed bench for bin_to_bcd_seq: a 6-digit/17-bit and a
// 4-digit/14-bit instance checked against an arithmetic decimal model.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        start_a, lz_a, busy_a, done_a, ovf_a;
  logic [16:0] bin_a;
  logic [23:0] bcd_a;

  logic        start_b, lz_b, busy_b, done_b, ovf_b;
  logic [13:0] bin_b;
  logic [15:0] bcd_b;

  int checks   = 0;
  int failures = 0;
  int done_cnt_a = 0;
  int done_cnt_b = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.BIN_W(17), .DIGITS(6)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .bin_in(bin_a), .lz_blank(lz_a),
    .busy(busy_a), .done(done_a), .ovf(ovf_a), .bcd_out(bcd_a)
  );

  bin_to_bcd_seq #(.BIN_W(14), .DIGITS(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .bin_in(bin_b), .lz_blank(lz_b),
    .busy(busy_b), .done(done_b), .ovf(ovf_b), .bcd_out(bcd_b)
  );

  always @(negedge clk) begin
    if (done_a === 1'b1) done_cnt_a++;
    if (done_b === 1'b1) done_cnt_b++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decimal model: {ovf, packed digits}. Uses plain div/mod, not dabbling.
  function automatic logic [32:0] ref_bcd(input int unsigned v, input int d, input bit lz);
    int unsigned lim = 1;
    int unsigned t;
    int unsigned dig;
    int top = 0;
    logic [31:0] r = '0;
    for (int i = 0; i < d; i++) lim = lim * 10;
    if (v >= lim) begin
      for (int i = 0; i < d; i++) r[4*i +: 4] = 4'h9;
      return {1'b1, r};
    end
    t = v;
    for (int i = 0; i < d; i++) begin
      dig = t % 10;
      t   = t / 10;
      r[4*i +: 4] = dig[3:0];
      if (dig != 0) top = i;
    end
    if (lz) for (int i = 1; i < d; i++) if (i > top) r[4*i +: 4] = 4'hF;
    return {1'b0, r};
  endfunction

  task automatic conv_a(input int unsigned v, input bit lz, input bit timing);
    logic [32:0] r;
    logic [23:0] held;
    int n, bc;
    r = ref_bcd(v, 6, lz);
    held = bcd_a;
    start_a = 1'b1; bin_a = v[16:0]; lz_a = lz;
    @(posedge clk); #1;
    start_a = 1'b0; bin_a = 17'($urandom); lz_a = 1'($urandom);
    n = 0;
    bc = busy_a ? 1 : 0;
    while (done_a !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (busy_a === 1'b1) bc++;
      if (n == 9) chk("hold_a", 32'(bcd_a), 32'(held));
    end
    chk("done_a", 32'(done_a), 32'd1);
    chk("bcd_a", 32'(bcd_a), 32'(r[23:0]));
    chk("ovf_a", 32'(ovf_a), 32'(r[32]));
    if (timing) begin
      chk("lat_a", n, 18);
      chk("busy_cyc_a", bc, 18);
    end
  endtask

  task automatic conv_b(input int unsigned v, input bit lz, input bit timing);
    logic [32:0] r;
    int n;
    r = ref_bcd(v, 4, lz);
    start_b = 1'b1; bin_b = v[13:0]; lz_b = lz;
    @(posedge clk); #1;
    start_b = 1'b0; bin_b = 14'($urandom); lz_b = 1'($urandom);
    n = 0;
    while (done_b !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_b", 32'(done_b), 32'd1);
    chk("bcd_b", 32'(bcd_b), 32'(r[15:0]));
    chk("ovf_b", 32'(ovf_b), 32'(r[32]));
    if (timing) chk("lat_b", n, 15);
  endtask

  initial begin
    int base, n;
    logic [32:0] r;
    rst_n = 1'b0;
    start_a = 1'b0; bin_a = '0; lz_a = 1'b0;
    start_b = 1'b0; bin_b = '0; lz_b = 1'b0;
    #23;
    chk("rst_bcd_a", 32'(bcd_a), 32'hFFFFF0);
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_done_a", 32'(done_a), 32'd0);
    chk("rst_ovf_a", 32'(ovf_a), 32'd0);
    chk("rst_bcd_b", 32'(bcd_b), 32'hFFF0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    conv_a(0, 1'b1, 1'b1);
    conv_a(2048, 1'b1, 1'b1);
    conv_a(2048, 1'b0, 1'b0);
    conv_a(131071, 1'b0, 1'b0);
    conv_a(99999, 1'b1, 1'b1);   // start driven in the done cycle
    conv_a(5, 1'b0, 1'b0);

    conv_b(12345, 1'b0, 1'b1);
    conv_b(7, 1'b1, 1'b0);
    conv_b(9999, 1'b0, 1'b0);
    conv_b(10000, 1'b1, 1'b0);

    // Starts while busy must be ignored.
    base = done_cnt_a;
    r = ref_bcd(500, 6, 1'b0);
    start_a = 1'b1; bin_a = 17'd500; lz_a = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 6; k++) begin
      start_a = 1'b1; bin_a = 17'($urandom); lz_a = 1'b1;
      @(posedge clk); #1;
    end
    start_a = 1'b0;
    n = 0;
    while (done_a !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("busy_start_bcd", 32'(bcd_a), 32'(r[23:0]));
    repeat (4) @(posedge clk);
    #1;
    chk("busy_start_dones", done_cnt_a - base, 1);

    // Reset in the middle of SHIFT aborts without a done pulse.
    start_a = 1'b1; bin_a = 17'd54321; lz_a = 1'b0;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    base = done_cnt_a;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy_a), 32'd0);
    chk("abort_bcd", 32'(bcd_a), 32'hFFFFF0);
    chk("abort_ovf", 32'(ovf_a), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt_a - base, 0);
    conv_a(2048, 1'b0, 1'b1);

    for (int i = 0; i < 16; i++) begin
      int unsigned v;
      v = (i % 2 == 0) ? $urandom_range(0, 131071) : $urandom_range(0, 999);
      conv_a(v, 1'($urandom), 1'b0);
    end
    for (int i = 0; i < 10; i++) begin
      conv_b($urandom_range(0, 16383), 1'($urandom), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method.
- Produces the packed BCD digit vector for the score/tile display path; each 4-bit digit drives one BCD-to-seven-segment digit decoder.
- Leading-zero digits can be replaced by the blank code 4'hF. The digit decoder renders any non-decimal code as blank.
- One conversion per start request, signalled by a one-cycle done pulse.

Parameters:
- BIN_W, 17, width of the binary input (score up to 131071).
- DIGITS, 6, number of BCD digits produced.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  conversion request; sampled only when busy=0.
- bin_in  input  BIN_W  binary value; captured on the accepted start edge.
- lz_blank  input  1  1 = replace leading zero digits with 4'hF; captured with start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse; bcd_out and ovf are valid and updated in the same cycle.
- ovf  output  1  last conversion exceeded 10^DIGITS-1; held until the next done.
- bcd_out  output  4*DIGITS  packed digits; digit 0 (least significant) is in bits [3:0]. Held stable between done pulses.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, rst_n.
- Reset values:
  - busy=0, done=0, ovf=0, state=IDLE.
  - bcd_out: digit 0 = 4'h0, all other digits = 4'hF (display shows a single "0").
- States: IDLE, SHIFT, FINISH.
- IDLE:
  - On a clock edge with start=1, capture bin_in into the shift register, capture lz_blank, clear the BCD scratch register and the overflow flag.
  - Load iteration counter = BIN_W; go to SHIFT; busy=1 from the next cycle.
- SHIFT, once per cycle:
  - For every scratch digit >= 5, add 3 (4-bit, no carry between digits).
  - Then shift {scratch, binreg} left by one bit.
  - The bit shifted out of the top digit sets the sticky overflow flag.
  - Decrement the counter. When the counter reaches 1 on this edge, go to FINISH.
  - Exactly BIN_W SHIFT cycles occur.
- FINISH, one cycle:
  - If overflow: bcd_out = all digits 4'h9, ovf=1.
  - Otherwise: bcd_out = scratch, ovf=0. If lz_blank is set, every digit above the most-significant nonzero digit becomes 4'hF. Digit 0 is never blanked.
  - done=1 for this cycle only; busy=0 on the following edge; return to IDLE.
- Latency: start accepted on edge E0; done high in the cycle after edge E(BIN_W+1). Total BIN_W+1 cycles. Back-to-back conversions are possible: start may be asserted in the done cycle and is accepted.
- start while busy=1 is ignored, not queued. bin_in and lz_blank changes during busy have no effect.
- Reset asserted mid-conversion aborts immediately: reset values apply and no done pulse is produced.
- Width rule: scratch register is 4*DIGITS bits. The add-3 compare is per 4-bit digit and unsigned.

Decomposition:
- Shared package bcd_pkg:
  - state enum {IDLE, SHIFT, FINISH}.
  - BCD_BLANK = 4'hF.
  - BCD_NINE = 4'h9.
  - DABBLE_THRESH = 4'd5.
  - Helper function for the counter width, clog2(BIN_W+1).
- Sub-module bcd_dabble_digit: combinational per-digit cell.
  - Inputs: 4-bit digit, shift-in bit.
  - Outputs: next digit, shift-out bit.
  - Instantiated DIGITS times in a chain. The top cell's shift-out drives overflow detection.

Test Plan:
- Reset, then bin_in=0, lz_blank=1, start -> done after 18 cycles; bcd_out=24'hFFFFF0, ovf=0.
- bin_in=2048, lz_blank=1 -> bcd_out=24'hFF2048. Same with lz_blank=0 -> 24'h002048. busy high for exactly 18 cycles.
- bin_in=131071 -> 24'h131071. Then bin_in=99999, lz_blank=1, start in the done cycle -> accepted; 24'hF99999.
- DIGITS=4, BIN_W=14, bin_in=12345 -> bcd_out=16'h9999, ovf=1. Next conversion bin_in=7 -> 16'hFFF7, ovf=0.
- start pulsed repeatedly during busy with different bin_in -> only the first value converts; exactly one done pulse.
- rst_n low at SHIFT cycle 5 -> busy=0 and bcd_out=24'hFFFFF0 asynchronously; no done pulse. A fresh start afterwards converts correctly.
